parking_lot_controller: RTL and testbench

Occupancy controller for the parking lot: watches the two gate photo-sensors, decodes complete car entry and exit sequences with a state machine, and keeps a saturating two-digit BCD occupancy count. Its `bcd` output drives the counter display block directly, which renders the digits and the FULL/CLEAR text. It also flags full/empty and reports rejected events.

---
 rtl/parking_pkg.sv | 22 ++
 rtl/bcd_updown_counter.sv | 48 ++++
 rtl/parking_lot_controller.sv | 146 ++++++++++++++
 tb/tb_parking_lot_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Purpose: shared types and constants for the parking lot occupancy controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DEFAULT_CAPACITY : lot capacity used when the top is not overridden
//   gate_state_t     : gate sequence decoder states (entry path A->AB->B, exit path B->BA->A)
package parking_pkg;

  localparam int DEFAULT_CAPACITY = 25;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENT_A  = 3'd1,
    ENT_AB = 3'd2,
    ENT_B  = 3'd3,
    EXT_B  = 3'd4,
    EXT_BA = 3'd5,
    EXT_A  = 3'd6
  } gate_state_t;

endpackage

// File: rtl/bcd_updown_counter.sv
// Purpose: two-digit BCD up/down counter, no saturation (caller gates inc/dec).
// Latency: bcd updates on the rising edge where inc or dec is sampled high.
// Backpressure: none; inc and dec together (or neither) hold the count.
//
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset (count -> 8'h00)
//   inc, dec     : single-cycle step requests
//   bcd[7:0]     : registered count, [7:4] tens, [3:0] ones
module bcd_updown_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] bcd
);

  logic [7:0] bcd_q, bcd_d;

  always_comb begin
    bcd_d = bcd_q;
    if (inc && !dec) begin
      if (bcd_q[3:0] == 4'd9) begin
        bcd_d[3:0] = 4'd0;
        bcd_d[7:4] = (bcd_q[7:4] == 4'd9) ? 4'd0 : bcd_q[7:4] + 4'd1;
      end else begin
        bcd_d[3:0] = bcd_q[3:0] + 4'd1;
      end
    end else if (dec && !inc) begin
      if (bcd_q[3:0] == 4'd0) begin
        bcd_d[3:0] = 4'd9;
        bcd_d[7:4] = (bcd_q[7:4] == 4'd0) ? 4'd9 : bcd_q[7:4] - 4'd1;
      end else begin
        bcd_d[3:0] = bcd_q[3:0] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_q <= 8'h00;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/parking_lot_controller.sv
// Purpose: decodes gate photo-sensor sequences into car entries/exits and keeps a saturating BCD occupancy.
// Latency: sensor level reaches the FSM after 2 edges; count and pulses register on the 3rd edge.
// Backpressure: none; completions at full/empty are discarded and reported on reject_pulse.
//
// Ports:
//   clk, reset_n        : clock and asynchronous active-low reset
//   sensor_a, sensor_b  : outer / inner beam, 1 = blocked, asynchronous to clk
//   bcd[7:0]            : occupancy, [7:4] tens, [3:0] ones
//   full, empty         : count == CAPACITY / count == 0
//   enter_pulse, exit_pulse, reject_pulse : one-cycle event pulses
module parking_lot_controller
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEFAULT_CAPACITY
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [7:0] bcd,
  output logic       full,
  output logic       empty,
  output logic       enter_pulse,
  output logic       exit_pulse,
  output logic       reject_pulse
);

  // Capacity expressed in the same BCD encoding as the count so full is a direct compare.
  localparam logic [7:0] CAP_BCD = 8'(((CAPACITY / 10) << 4) | (CAPACITY % 10));

  logic [1:0]  a_sync_q, a_sync_d;
  logic [1:0]  b_sync_q, b_sync_d;
  logic        a_s, b_s;
  logic [1:0]  ab;
  gate_state_t state_q, state_d;
  logic        entry_done, exit_done;
  logic        inc, dec;
  logic        enter_pulse_q, enter_pulse_d;
  logic        exit_pulse_q, exit_pulse_d;
  logic        reject_pulse_q, reject_pulse_d;

  // Two-flop synchronizers; bit 0 is the metastability stage.
  always_comb begin
    a_sync_d = {a_sync_q[0], sensor_a};
    b_sync_d = {b_sync_q[0], sensor_b};
  end

  assign a_s = a_sync_q[1];
  assign b_s = b_sync_q[1];
  assign ab  = {a_s, b_s};

  // Entry path walks A -> AB -> B -> clear; exit path is the mirror image.
  always_comb begin
    state_d    = state_q;
    entry_done = 1'b0;
    exit_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ab == 2'b10)      state_d = ENT_A;
        else if (ab == 2'b01) state_d = EXT_B;
      end
      ENT_A: begin
        if (ab == 2'b11)      state_d = ENT_AB;
        else if (ab != 2'b10) state_d = IDLE;
      end
      ENT_AB: begin
        if (ab == 2'b01)      state_d = ENT_B;
        else if (ab == 2'b10) state_d = ENT_A;   // car backed up
        else if (ab == 2'b00) state_d = IDLE;
      end
      ENT_B: begin
        if (ab == 2'b00) begin
          state_d    = IDLE;
          entry_done = 1'b1;
        end else if (ab == 2'b11) begin
          state_d = ENT_AB;
        end else if (ab == 2'b10) begin
          state_d = IDLE;
        end
      end
      EXT_B: begin
        if (ab == 2'b11)      state_d = EXT_BA;
        else if (ab != 2'b01) state_d = IDLE;
      end
      EXT_BA: begin
        if (ab == 2'b10)      state_d = EXT_A;
        else if (ab == 2'b01) state_d = EXT_B;
        else if (ab == 2'b00) state_d = IDLE;
      end
      EXT_A: begin
        if (ab == 2'b00) begin
          state_d   = IDLE;
          exit_done = 1'b1;
        end else if (ab == 2'b11) begin
          state_d = EXT_BA;
        end else if (ab == 2'b01) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The count never exceeds CAPACITY, so "not full" is the same as count < CAPACITY.
  assign full  = (bcd == CAP_BCD);
  assign empty = (bcd == 8'h00);
  assign inc   = entry_done && !full;
  assign dec   = exit_done && !empty;

  always_comb begin
    enter_pulse_d  = inc;
    exit_pulse_d   = dec;
    reject_pulse_d = (entry_done && full) || (exit_done && empty);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sync_q       <= 2'b00;
      b_sync_q       <= 2'b00;
      state_q        <= IDLE;
      enter_pulse_q  <= 1'b0;
      exit_pulse_q   <= 1'b0;
      reject_pulse_q <= 1'b0;
    end else begin
      a_sync_q       <= a_sync_d;
      b_sync_q       <= b_sync_d;
      state_q        <= state_d;
      enter_pulse_q  <= enter_pulse_d;
      exit_pulse_q   <= exit_pulse_d;
      reject_pulse_q <= reject_pulse_d;
    end
  end

  bcd_updown_counter u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc),
    .dec     (dec),
    .bcd     (bcd)
  );

  assign enter_pulse  = enter_pulse_q;
  assign exit_pulse   = exit_pulse_q;
  assign reject_pulse = reject_pulse_q;

endmodule

// File: tb/tb_parking_lot_controller.sv
// Purpose: directed bench for parking_lot_controller with a pulse scoreboard.
// Latency: expects each event pulse exactly 3 edges after the completing code is driven.
// Backpressure: n/a.
module tb_parking_lot_controller;

  localparam int CAP = 25;
  localparam logic [2:0] K_ENT = 3'b100;
  localparam logic [2:0] K_EXT = 3'b010;
  localparam logic [2:0] K_REJ = 3'b001;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sensor_a, sensor_b;
  logic [7:0] bcd;
  logic       full, empty;
  logic       enter_pulse, exit_pulse, reject_pulse;

  parking_lot_controller #(.CAPACITY(CAP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sensor_a     (sensor_a),
    .sensor_b     (sensor_b),
    .bcd          (bcd),
    .full         (full),
    .empty        (empty),
    .enter_pulse  (enter_pulse),
    .exit_pulse   (exit_pulse),
    .reject_pulse (reject_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] bcd;
    logic       full;
    logic       empty;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   misc = 0;
  int   cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one sensor code, held 4 cycles; kind != 0 queues the event that code completes.
  task automatic step(input logic [1:0] code, input logic [2:0] kind);
    exp_t e;
    {sensor_a, sensor_b} = code;
    if (kind != 3'b000) begin
      e.kind  = kind;
      e.bcd   = to_bcd(cnt);
      e.full  = (cnt == CAP);
      e.empty = (cnt == 0);
      e.cyc   = cyc + 3;
      exp_q.push_back(e);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic enter_car();
    logic [2:0] k;
    step(2'b00, 3'b000);
    step(2'b10, 3'b000);
    step(2'b11, 3'b000);
    step(2'b01, 3'b000);
    if (cnt < CAP) begin cnt++; k = K_ENT; end
    else k = K_REJ;
    step(2'b00, k);
  endtask

  task automatic exit_car();
    logic [2:0] k;
    step(2'b00, 3'b000);
    step(2'b01, 3'b000);
    step(2'b11, 3'b000);
    step(2'b10, 3'b000);
    if (cnt > 0) begin cnt--; k = K_EXT; end
    else k = K_REJ;
    step(2'b00, k);
  endtask

  task automatic chk_levels(input string nm);
    chk({nm, "_bcd"}, int'(bcd), int'(to_bcd(cnt)));
    chk({nm, "_flags"}, int'({full, empty}), int'({cnt == CAP, cnt == 0}));
  endtask

  // Monitor: every pulse cycle must match the head of the scoreboard, on the predicted cycle.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (enter_pulse || exit_pulse || reject_pulse) begin
        vectors++;
        if (exp_q.size() == 0) begin
          misc++;
          $display("FAIL unexpected_pulse: got ent/ext/rej=%b%b%b at cycle %0d, none expected",
                   enter_pulse, exit_pulse, reject_pulse, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({enter_pulse, exit_pulse, reject_pulse} !== e.kind || bcd !== e.bcd ||
              full !== e.full || empty !== e.empty || cyc != e.cyc) begin
            misc++;
            $display("FAIL pulse_event: got kind=%b bcd=%h full=%b empty=%b cyc=%0d expected kind=%b bcd=%h full=%b empty=%b cyc=%0d",
                     {enter_pulse, exit_pulse, reject_pulse}, bcd, full, empty, cyc,
                     e.kind, e.bcd, e.full, e.empty, e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        misc++;
        $display("FAIL missing_pulse: got no pulse by cycle %0d expected kind=%b at cycle %0d",
                 cyc, e.kind, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    misc++;
    $display("FAIL timeout: got no end of test expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bcd", int'(bcd), 8'h00);
    chk("reset_flags", int'({full, empty}), 2'b01);
    chk("reset_pulses", int'({enter_pulse, exit_pulse, reject_pulse}), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // First car in.
    enter_car();
    chk_levels("first_entry");

    // Ones-digit carry 09 -> 10 and borrow 10 -> 09.
    repeat (8) enter_car();
    chk("count_09", int'(bcd), 8'h09);
    enter_car();
    chk("carry_10", int'(bcd), 8'h10);
    exit_car();
    chk("borrow_09", int'(bcd), 8'h09);

    // Fill to capacity, then one more is rejected.
    repeat (16) enter_car();
    chk("at_capacity_bcd", int'(bcd), 8'h25);
    chk("at_capacity_full", int'(full), 1);
    enter_car();
    chk_levels("reject_at_full");
    exit_car();
    chk("after_full_exit_bcd", int'(bcd), 8'h24);
    chk("after_full_exit_full", int'(full), 0);

    // Drain, then exit at empty is rejected.
    repeat (24) exit_car();
    chk_levels("drained");
    exit_car();
    chk_levels("reject_at_empty");

    // Pedestrian on the outer beam only.
    step(2'b00, 3'b000);
    step(2'b10, 3'b000);
    step(2'b00, 3'b000);
    chk_levels("pedestrian");

    // Entry with a backup: one increment only.
    step(2'b00, 3'b000);
    step(2'b10, 3'b000);
    step(2'b11, 3'b000);
    step(2'b10, 3'b000);
    step(2'b11, 3'b000);
    step(2'b01, 3'b000);
    cnt++;
    step(2'b00, K_ENT);
    chk_levels("backup_entry");

    // Aborted entry.
    step(2'b10, 3'b000);
    step(2'b11, 3'b000);
    step(2'b00, 3'b000);
    chk_levels("aborted_entry");

    // Reset while a car sits in ENT_AB with count 7.
    repeat (6) enter_car();
    chk("pre_reset_bcd", int'(bcd), 8'h07);
    step(2'b10, 3'b000);
    step(2'b11, 3'b000);
    #3;
    reset_n = 1'b0;
    #1;
    cnt = 0;
    chk("async_reset_bcd", int'(bcd), 8'h00);
    chk("async_reset_flags", int'({full, empty}), 2'b01);
    chk("async_reset_pulses", int'({enter_pulse, exit_pulse, reject_pulse}), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(2'b01, 3'b000);
    step(2'b00, 3'b000);
    step(2'b00, 3'b000);
    chk_levels("trailing_after_reset");

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
